// File: rtl/voice_scheduler.sv
// Time-multiplexed phase-accumulator scheduler for the sine synth path.
// One shared ROM port and adder serve all voices once per sample tick.
module voice_scheduler #(
    parameter int NUM_VOICES   = 8,
    parameter int PHASE_WIDTH  = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int SAMPLE_WIDTH = 8
) (
    input  logic                                         clk_in,
    input  logic                                         rst_in,
    input  logic                                         tick_in,
    input  logic [NUM_VOICES-1:0]                        gate_in,
    input  logic                                         inc_we_in,
    input  logic [$clog2(NUM_VOICES)-1:0]                inc_addr_in,
    input  logic [PHASE_WIDTH-1:0]                       inc_data_in,
    output logic                                         rom_req_out,
    output logic [ADDR_WIDTH-1:0]                        rom_addr_out,
    input  logic                                         rom_ack_in,
    input  logic [SAMPLE_WIDTH-1:0]                      rom_data_in,
    output logic [SAMPLE_WIDTH+$clog2(NUM_VOICES)-1:0]   sample_out,
    output logic                                         sample_valid_out,
    output logic                                         busy_out,
    output logic                                         overrun_out
);

    localparam int VW = $clog2(NUM_VOICES);
    localparam int MW = SAMPLE_WIDTH + VW;
    localparam logic [VW-1:0] LAST = VW'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [PHASE_WIDTH-1:0] phase [NUM_VOICES];
    logic [PHASE_WIDTH-1:0] inc   [NUM_VOICES];
    logic [NUM_VOICES-1:0]  gate_q;
    logic [VW-1:0]          v;
    logic [MW-1:0]          mix;
    logic                   start;
    logic                   adv;
    logic                   done;
    logic [MW-1:0]          data_ext;

    function automatic logic [PHASE_WIDTH-1:0] inc_default(input int i);
        case (i)
            0:       return PHASE_WIDTH'(112404);
            1:       return PHASE_WIDTH'(126156);
            2:       return PHASE_WIDTH'(141526);
            3:       return PHASE_WIDTH'(149664);
            4:       return PHASE_WIDTH'(167772);
            5:       return PHASE_WIDTH'(188743);
            6:       return PHASE_WIDTH'(211688);
            7:       return PHASE_WIDTH'(224003);
            default: return '0;
        endcase
    endfunction

    assign data_ext = {{VW{rom_data_in[SAMPLE_WIDTH-1]}}, rom_data_in};
    assign rom_addr_out = phase[v][PHASE_WIDTH-1 -: ADDR_WIDTH];

    always_comb begin
        state_d     = state_q;
        rom_req_out = 1'b0;
        start       = 1'b0;
        adv         = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick_in) begin
                    start   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                rom_req_out = gate_q[v];
                adv         = !gate_q[v] || rom_ack_in;
                if (adv && v == LAST)
                    state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q          <= IDLE;
            gate_q           <= '0;
            v                <= '0;
            mix              <= '0;
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
            busy_out         <= 1'b0;
            overrun_out      <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
                inc[i]   <= inc_default(i);
            end
        end else begin
            state_q          <= state_d;
            sample_valid_out <= done;
            // Table write lands with the old value still used by this edge's update.
            if (inc_we_in)
                inc[inc_addr_in] <= inc_data_in;
            if (tick_in && busy_out)
                overrun_out <= 1'b1;
            if (start) begin
                gate_q   <= gate_in;
                v        <= '0;
                mix      <= '0;
                busy_out <= 1'b1;
            end
            if (state_q == RUN) begin
                if (!gate_q[v]) begin
                    phase[v] <= '0;
                end else if (rom_ack_in) begin
                    mix      <= mix + data_ext;
                    phase[v] <= phase[v] + inc[v];
                end
                if (adv && v != LAST)
                    v <= v + 1'b1;
            end
            if (done) begin
                sample_out <= mix;
                busy_out   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: latency, mixing, wait states,
// overrun, phase wrap and asynchronous reset.
module tb_voice_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        tick_in = 1'b0;
    logic [7:0]  gate_in = '0;
    logic        inc_we_in = 1'b0;
    logic [2:0]  inc_addr_in = '0;
    logic [31:0] inc_data_in = '0;
    logic        rom_req_out;
    logic [7:0]  rom_addr_out;
    logic        rom_ack_in = 1'b1;
    logic [7:0]  rom_data_in = '0;
    logic [10:0] sample_out;
    logic        sample_valid_out;
    logic        busy_out;
    logic        overrun_out;

    int tests = 0;
    int failed = 0;
    int wait_cfg = 0;
    int wcnt = 0;

    int lat, reqc, nreq, vcnt, addr_bad;

    voice_scheduler dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .tick_in(tick_in),
        .gate_in(gate_in),
        .inc_we_in(inc_we_in),
        .inc_addr_in(inc_addr_in),
        .inc_data_in(inc_data_in),
        .rom_req_out(rom_req_out),
        .rom_addr_out(rom_addr_out),
        .rom_ack_in(rom_ack_in),
        .rom_data_in(rom_data_in),
        .sample_out(sample_out),
        .sample_valid_out(sample_valid_out),
        .busy_out(busy_out),
        .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    // ROM model: ack after wait_cfg idle cycles of a held request
    always @(negedge clk_in) begin
        if (rom_req_out) begin
            rom_ack_in = (wcnt >= wait_cfg);
            wcnt = (wcnt >= wait_cfg) ? 0 : wcnt + 1;
        end else begin
            rom_ack_in = (wait_cfg == 0);
            wcnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_inc(input logic [2:0] a, input logic [31:0] d);
        inc_we_in = 1'b1;
        inc_addr_in = a;
        inc_data_in = d;
        @(posedge clk_in);
        #1;
        inc_we_in = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] g, input int tick_at,
                             output int o_lat, output int o_reqc,
                             output int o_nreq, output int o_vcnt,
                             output int o_abad);
        logic       prev_req;
        logic [7:0] prev_addr;
        gate_in = g;
        tick_in = 1'b1;
        @(posedge clk_in);
        #1;
        tick_in = 1'b0;
        o_lat = -1;
        o_reqc = 0;
        o_nreq = 0;
        o_vcnt = 0;
        o_abad = 0;
        prev_req = 1'b0;
        prev_addr = '0;
        for (int k = 0; k < 60; k++) begin
            if (k == tick_at) tick_in = 1'b1;
            if (k == tick_at + 1) tick_in = 1'b0;
            if (rom_req_out) begin
                o_reqc++;
                if (!prev_req || rom_ack_in) o_nreq++;
                else if (rom_addr_out !== prev_addr) o_abad++;
            end
            if (sample_valid_out) begin
                o_vcnt++;
                if (o_lat < 0) o_lat = k;
            end
            prev_req = rom_req_out;
            prev_addr = rom_addr_out;
            if (o_lat >= 0 && k > o_lat + 2) break;
            @(posedge clk_in);
            #1;
        end
        tick_in = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_req", rom_req_out, 1'b0);
        chk("rst_busy", busy_out, 1'b0);
        chk("rst_valid", sample_valid_out, 1'b0);
        chk("rst_overrun", overrun_out, 1'b0);
        chk("rst_sample", sample_out, 11'h000);
        chk("rst_inc7", dut.inc[7], 32'd224003);
        #4 rst_in = 1'b1;
        @(posedge clk_in);
        #1;

        rom_data_in = 8'd10;
        run_frame(8'h01, -1, lat, reqc, nreq, vcnt, addr_bad);
        chk("single_lat", lat, 9);
        chk("single_reqc", reqc, 1);
        chk("single_vcnt", vcnt, 1);
        chk("single_sample", sample_out, 11'd10);
        chk("single_phase0", dut.phase[0], 32'd112404);
        chk("single_phase1", dut.phase[1], 32'd0);
        chk("single_overrun", overrun_out, 1'b0);

        rom_data_in = 8'd127;
        run_frame(8'hFF, -1, lat, reqc, nreq, vcnt, addr_bad);
        chk("chord_pos", sample_out, 11'd1016);
        chk("chord_nreq", nreq, 8);
        chk("chord_lat", lat, 9);
        chk("chord_phase7", dut.phase[7], 32'd224003);

        rom_data_in = 8'h80;
        run_frame(8'hFF, -1, lat, reqc, nreq, vcnt, addr_bad);
        chk("chord_neg", sample_out, 11'h400);
        chk("chord_neg_phase0", dut.phase[0], 32'd337212);

        wait_cfg = 3;
        rom_data_in = 8'd5;
        run_frame(8'h05, -1, lat, reqc, nreq, vcnt, addr_bad);
        chk("wait_lat", lat, 15);
        chk("wait_nreq", nreq, 2);
        chk("wait_reqc", reqc, 8);
        chk("wait_addr_stable", addr_bad, 0);
        chk("wait_sample", sample_out, 11'd10);
        chk("wait_phase1", dut.phase[1], 32'd0);
        chk("wait_phase2", dut.phase[2], 32'd424578);
        wait_cfg = 0;
        @(posedge clk_in);
        #1;

        rom_data_in = 8'd3;
        run_frame(8'h01, 3, lat, reqc, nreq, vcnt, addr_bad);
        chk("ovr_flag", overrun_out, 1'b1);
        chk("ovr_lat", lat, 9);
        chk("ovr_vcnt", vcnt, 1);
        chk("ovr_sample", sample_out, 11'd3);

        write_inc(3'd3, 32'd1);
        rom_data_in = 8'd0;
        run_frame(8'h08, -1, lat, reqc, nreq, vcnt, addr_bad);
        chk("wrap_pre", dut.phase[3], 32'd1);
        write_inc(3'd3, 32'hFFFF_FFFF);
        run_frame(8'h08, -1, lat, reqc, nreq, vcnt, addr_bad);
        chk("wrap_phase3", dut.phase[3], 32'd0);
        chk("wrap_phase0", dut.phase[0], 32'd0);
        chk("ovr_sticky", overrun_out, 1'b1);

        run_frame(8'h00, -1, lat, reqc, nreq, vcnt, addr_bad);
        chk("off_sample", sample_out, 11'd0);
        chk("off_vcnt", vcnt, 1);
        chk("off_nreq", nreq, 0);

        write_inc(3'd0, 32'd5);
        wait_cfg = 3;
        gate_in = 8'h01;
        tick_in = 1'b1;
        @(posedge clk_in);
        #1;
        tick_in = 1'b0;
        chk("mid_req", rom_req_out, 1'b1);
        #2 rst_in = 1'b0;
        #1;
        chk("arst_req", rom_req_out, 1'b0);
        chk("arst_busy", busy_out, 1'b0);
        chk("arst_valid", sample_valid_out, 1'b0);
        chk("arst_overrun", overrun_out, 1'b0);
        chk("arst_inc0", dut.inc[0], 32'd112404);
        wait_cfg = 0;
        #4 rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rom_data_in = 8'd1;
        run_frame(8'h01, -1, lat, reqc, nreq, vcnt, addr_bad);
        chk("post_rst_phase0", dut.phase[0], 32'd112404);
        chk("post_rst_sample", sample_out, 11'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
- Time-multiplexed phase-accumulator controller for the sine-wave synth path.
- On each sample tick it walks all voices in order and, for every gated voice, requests the shared sine ROM at that voice's phase, mixes the returned sample and advances the phase.
- It emits one mixed sample per tick.
- It replaces per-voice adders with one shared adder and one shared ROM port. It sits between the gate/keyboard logic and the audio output stage.

Parameters:
- NUM_VOICES, 8, number of voices scheduled per frame.
- PHASE_WIDTH, 32, phase accumulator width.
- ADDR_WIDTH, 8, ROM address width; address = top ADDR_WIDTH bits of phase.
- SAMPLE_WIDTH, 8, signed ROM sample width.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- tick_in  in  1  sample-rate strobe, one cycle wide.
- gate_in  in  NUM_VOICES  per-voice note-on.
- inc_we_in  in  1  phase-increment write enable.
- inc_addr_in  in  $clog2(NUM_VOICES)  voice index for write.
- inc_data_in  in  PHASE_WIDTH  new phase increment.
- rom_req_out  out  1  shared ROM request.
- rom_addr_out  out  ADDR_WIDTH  ROM address.
- rom_ack_in  in  1  ROM data valid for current request.
- rom_data_in  in  SAMPLE_WIDTH  signed sine sample.
- sample_out  out  SAMPLE_WIDTH+$clog2(NUM_VOICES)  signed mixed sample.
- sample_valid_out  out  1  one-cycle pulse, new sample.
- busy_out  out  1  frame in progress.
- overrun_out  out  1  sticky: tick arrived while busy.

Behaviour:
- Reset (rst_in low, asynchronous, any state) clears the following immediately:
  - state goes to IDLE, all phases 0, voice index 0, mix 0, sample_out 0.
  - sample_valid_out, busy_out, overrun_out and rom_req_out go to 0.
  - Increment table is loaded with 112404, 126156, 141526, 149664, 167772, 188743, 211688, 224003 for voices 0..7; any voice >= 8 gets 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - tick_in high causes: gate_q <= gate_in (frozen for the frame), v <= 0, mix <= 0, busy_out <= 1, next state RUN.
- RUN, evaluated for voice v each cycle:
  - gate_q[v] = 0: phase[v] <= 0, no request, advance in 1 cycle.
  - gate_q[v] = 1: rom_req_out = 1 (combinational from state/v/gate_q), rom_addr_out = phase[v][PHASE_WIDTH-1 -: ADDR_WIDTH].
  - Request is held with a stable address until rom_ack_in = 1 on a clock edge. On that edge: mix <= mix + sign-extended rom_data_in, phase[v] <= phase[v] + inc[v] (modulo 2^PHASE_WIDTH, wraps silently), then advance.
  - Zero-wait ack (ack in the same cycle as req) is legal.
  - Advance: if v == NUM_VOICES-1, next state DONE; else v <= v+1.
- DONE:
  - sample_out <= mix, sample_valid_out <= 1 for exactly one cycle, busy_out <= 0, next state IDLE.
  - sample_out holds until the next DONE.
- Latency with zero-wait ROM: tick sampled at edge T; sample_valid_out high in the cycle after edge T+NUM_VOICES+1. ROM wait states add 1:1.
- Mix width: SAMPLE_WIDTH+$clog2(NUM_VOICES) bits, so 8 full-scale voices cannot overflow.
- tick_in while busy_out = 1 (RUN or DONE): tick is ignored, overrun_out <= 1 (sticky until reset), frame continues undisturbed.
- Increment writes are accepted in any state. inc[inc_addr_in] <= inc_data_in on the edge. If a write and the voice's phase update fall on the same edge, the update uses the old increment.
- gate_in changes mid-frame have no effect until the next tick.
- All voices gated off: frame still runs, all phases go to 0, sample_out = 0, valid pulse still produced.

Test Plan:
- Single voice: gate_in = 8'h01, ack tied 1, rom_data_in = 8'sd10, one tick → rom_req_out high exactly 1 cycle with addr 0. After the frame, sample_out = 10, phase[0] = 112404, valid pulses once, 9 cycles after the tick edge.
- Full chord: gate_in = 8'hFF, rom_data_in = 8'sd127 → sample_out = 1016, no truncation. Repeat with -128 → sample_out = -1024.
- ROM wait states: gate_in = 8'h05, ack delayed 3 cycles per request → rom_addr_out stable while req high, valid arrives 6 cycles later than the zero-wait case, only voices 0 and 2 requested.
- Overrun and phase wrap:
  - tick during RUN → overrun_out = 1 and stays 1; output unchanged.
  - Write inc[3] = 32'hFFFF_FFFF with phase[3] = 1 → next phase[3] = 0.
- Reset mid-frame: assert rst_in low while rom_req_out = 1 → req, busy and valid go to 0 without a clock edge, and the increment table returns to defaults. A following tick with gate_in = 8'h01 yields phase[0] = 112404.
